// File: rtl/avl_st_pkg.sv
// avl_st_pkg: shared state type and default widths for the mini Avalon-ST blocks.
package avl_st_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 16;
   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} st_state_e;
endpackage

// File: rtl/avl_st_mini_if.sv
// avl_st_mini_if: minimal Avalon-ST link (valid/ready, sop/eop, data).
interface avl_st_mini_if #(parameter int DATA_WIDTH = 32);
   logic                  valid;
   logic                  ready;
   logic                  startofpacket;
   logic                  endofpacket;
   logic [DATA_WIDTH-1:0] data;
   modport src (output valid, startofpacket, endofpacket, data, input ready);
   modport snk (input valid, startofpacket, endofpacket, data, output ready);
endinterface

// File: rtl/st_packet_source.sv
// st_packet_source: emits one packet of incrementing words per accepted command, honouring backpressure.
module st_packet_source
   import avl_st_pkg::*;
#(
   parameter int DATA_WIDTH = avl_st_pkg::DATA_WIDTH,
   parameter int LEN_WIDTH  = avl_st_pkg::LEN_WIDTH,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [DATA_WIDTH-1:0] cmd_seed,
   avl_st_mini_if.src            o_st_if,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pkt_count,
   output logic                  zero_len_err
);
   st_state_e             state_q, state_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, zerr_q, zerr_d;
   logic                  xfer, last, accept, new_pkt;

   assign xfer      = valid_q & o_st_if.ready;
   assign last      = xfer & eop_q;
   // the last-beat cycle also accepts a command so packets can run back-to-back
   assign cmd_ready = (state_q == IDLE) | last;
   assign accept    = cmd_valid & cmd_ready;
   assign new_pkt   = accept & (cmd_len != '0);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      zerr_d  = accept & (cmd_len == '0);
      cnt_d   = cnt_q + CNT_WIDTH'(last);
      if (new_pkt) begin
         state_d = SEND;
         rem_d   = cmd_len;
         data_d  = cmd_seed;
         valid_d = 1'b1;
         sop_d   = 1'b1;
         eop_d   = cmd_len == LEN_WIDTH'(1);
      end else if (last) begin
         state_d = IDLE;
         valid_d = 1'b0;
         sop_d   = 1'b0;
         eop_d   = 1'b0;
      end else if (xfer) begin
         rem_d  = rem_q - LEN_WIDTH'(1);
         data_d = data_q + DATA_WIDTH'(1);
         sop_d  = 1'b0;
         eop_d  = rem_q == LEN_WIDTH'(2);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         zerr_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         zerr_q  <= zerr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_st_if.valid         = valid_q;
   assign o_st_if.startofpacket = sop_q;
   assign o_st_if.endofpacket   = eop_q;
   assign o_st_if.data          = data_q;
   assign busy                  = state_q == SEND;
   assign pkt_count             = cnt_q;
   assign zero_len_err          = zerr_q;
endmodule

// File: tb/tb_st_packet_source.sv
// tb_st_packet_source: directed checks of st_packet_source against hand-computed beats.
module tb_st_packet_source;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_len = '0;
   logic [31:0] cmd_seed = '0;
   logic        busy;
   logic [31:0] pkt_count;
   logic        zero_len_err;
   int          total = 0;
   int          bad = 0;

   avl_st_mini_if #(.DATA_WIDTH(32)) st_if ();

   st_packet_source dut (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_len(cmd_len), .cmd_seed(cmd_seed), .o_st_if(st_if), .busy(busy),
      .pkt_count(pkt_count), .zero_len_err(zero_len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [15:0] len, input logic [31:0] seed);
      cmd_valid = 1'b1;
      cmd_len   = len;
      cmd_seed  = seed;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [31:0] d, input logic sop, input logic eop);
      chk({tag, "_valid"}, 64'(st_if.valid), 64'd1);
      chk({tag, "_data"}, 64'(st_if.data), 64'(d));
      chk({tag, "_sop"}, 64'(st_if.startofpacket), 64'(sop));
      chk({tag, "_eop"}, 64'(st_if.endofpacket), 64'(eop));
   endtask

   initial begin
      logic [5:0] pat;
      int k;
      st_if.ready = 1'b1;
      #12;
      chk("rst_valid", 64'(st_if.valid), 64'd0);
      chk("rst_data", 64'(st_if.data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cnt", 64'(pkt_count), 64'd0);
      reset_n = 1'b1;
      tick();
      chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
      // basic packet
      send_cmd(16'd4, 32'h10);
      chk("basic_cmd_ready_send", 64'(cmd_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         beat("basic", 32'h10 + 32'(i), i == 0, i == 3);
         chk("basic_busy", 64'(busy), 64'd1);
         tick();
      end
      chk("basic_valid_off", 64'(st_if.valid), 64'd0);
      chk("basic_busy_off", 64'(busy), 64'd0);
      chk("basic_cnt", 64'(pkt_count), 64'd1);
      // single beat
      send_cmd(16'd1, 32'hABCD);
      beat("single", 32'hABCD, 1'b1, 1'b1);
      tick();
      chk("single_valid_off", 64'(st_if.valid), 64'd0);
      chk("single_busy_off", 64'(busy), 64'd0);
      chk("single_cnt", 64'(pkt_count), 64'd2);
      // backpressure: ready 1,0,0,1,0,1 in that order
      send_cmd(16'd3, 32'h0);
      pat = 6'b101001;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         st_if.ready = pat[i];
         #1;
         beat("bp", 32'(k), k == 0, k == 2);
         tick();
         if (pat[i]) k++;
      end
      st_if.ready = 1'b1;
      chk("bp_valid_off", 64'(st_if.valid), 64'd0);
      chk("bp_cnt", 64'(pkt_count), 64'd3);
      // back-to-back
      send_cmd(16'd2, 32'h200);
      beat("b2b_a0", 32'h200, 1'b1, 1'b0);
      tick();
      beat("b2b_a1", 32'h201, 1'b0, 1'b1);
      cmd_valid = 1'b1; cmd_len = 16'd2; cmd_seed = 32'h100;
      #1;
      chk("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      beat("b2b_b0", 32'h100, 1'b1, 1'b0);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_cnt_mid", 64'(pkt_count), 64'd4);
      tick();
      beat("b2b_b1", 32'h101, 1'b0, 1'b1);
      tick();
      chk("b2b_valid_off", 64'(st_if.valid), 64'd0);
      chk("b2b_cnt", 64'(pkt_count), 64'd5);
      // zero length
      send_cmd(16'd0, 32'h55);
      chk("zero_err", 64'(zero_len_err), 64'd1);
      chk("zero_valid", 64'(st_if.valid), 64'd0);
      chk("zero_busy", 64'(busy), 64'd0);
      tick();
      chk("zero_err_clr", 64'(zero_len_err), 64'd0);
      chk("zero_cnt", 64'(pkt_count), 64'd5);
      // data wrap
      send_cmd(16'd2, 32'hFFFF_FFFF);
      beat("wrap0", 32'hFFFF_FFFF, 1'b1, 1'b0);
      tick();
      beat("wrap1", 32'h0, 1'b0, 1'b1);
      tick();
      chk("wrap_cnt", 64'(pkt_count), 64'd6);
      // reset mid-packet after beat 3 transfers
      send_cmd(16'd8, 32'h40);
      for (int i = 0; i < 4; i++) tick();
      beat("mid_b4", 32'h44, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_valid", 64'(st_if.valid), 64'd0);
      chk("mid_cnt", 64'(pkt_count), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      send_cmd(16'd2, 32'h7);
      beat("post0", 32'h7, 1'b1, 1'b0);
      tick();
      beat("post1", 32'h8, 1'b0, 1'b1);
      tick();
      chk("post_valid_off", 64'(st_if.valid), 64'd0);
      chk("post_cnt", 64'(pkt_count), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
